if_id_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage. Accepts {PC, instruction} pairs produced by fetch through a valid/ready handshake and presents them in order to decode. It decouples decode stalls from fetch: back-pressure reaches the PC hold control only when the queue is full. It also discards all in-flight fetched instructions on a branch/jump flush.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/if_id_queue.sv | 111 +++++++++++
 tb/tb_if_id_queue.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared CPU constants used by the fetch/decode pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Default datapath width for PCs and instruction words
  localparam int XLEN = 32;

  // Canonical NOP (addi x0, x0, 0) presented to decode when nothing is queued
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : Fetch-to-decode instruction queue. Circular buffer of
//               {PC, instruction} pairs with valid/ready handshakes on both
//               sides, whole-queue flush on redirect, and a sticky error flag
//               for pushes attempted while full.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int DATA_XLEN = cpu_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [DATA_XLEN-1:0]       fetch_pc,
  input  logic [DATA_XLEN-1:0]       fetch_instr,
  output logic                       fetch_ready,
  output logic                       dec_valid,
  output logic [DATA_XLEN-1:0]       dec_pc,
  output logic [DATA_XLEN-1:0]       dec_instr,
  input  logic                       dec_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_XLEN-1:0] pc_mem    [DEPTH];
  logic [DATA_XLEN-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;

  logic push;
  logic pop;
  logic full;
  logic empty;

  // Handshake qualifiers derive only from registered occupancy, so there is
  // no combinational path from dec_ready back to fetch_ready.
  always_comb begin
    full  = (occ == CNT_FULL);
    empty = (occ == '0);
    push  = fetch_valid && !full;
    pop   = !empty && dec_ready;
  end

  // Head presentation; outputs are masked to a NOP when the queue is empty.
  always_comb begin
    fetch_ready = !full;
    dec_valid   = !empty;
    count       = occ;
    dec_pc      = '0;
    dec_instr   = DATA_XLEN'(NOP_INSTR);
    if (!empty) begin
      dec_pc    = pc_mem[rd_ptr];
      dec_instr = instr_mem[rd_ptr];
    end
  end

  // Pointer and occupancy bookkeeping; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + CNT_ONE;
        2'b01:   occ <= occ - CNT_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Sticky protocol error: fetch kept presenting a pair while the queue was full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_err <= 1'b0;
    end else if (fetch_valid && full && !flush) begin
      overflow_err <= 1'b1;
    end
  end

  // Entry storage is intentionally not reset; every read is masked by occupancy.
  always_ff @(posedge clk) begin
    if (rst && !flush && push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= fetch_instr;
    end
  end

endmodule : if_id_queue
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Directed self-checking bench for if_id_queue (DEPTH = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_ready;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_ready;
  logic        flush;
  logic [1:0]  count;
  logic        overflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  if_id_queue #(.DEPTH(2), .DATA_XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .fetch_instr  (fetch_instr),
    .fetch_ready  (fetch_ready),
    .dec_valid    (dec_valid),
    .dec_pc       (dec_pc),
    .dec_instr    (dec_instr),
    .dec_ready    (dec_ready),
    .flush        (flush),
    .count        (count),
    .overflow_err (overflow_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Directed stimulus
  initial begin
    rst         = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0;
    fetch_instr = 32'h0;
    dec_ready   = 1'b0;
    flush       = 1'b0;

    // Reset held two cycles with fetch_valid asserted
    tick();
    tick();
    check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    check("rst_dec_valid",   32'(dec_valid),   32'd0);
    check("rst_dec_pc",      dec_pc,           32'h0);
    check("rst_dec_instr",   dec_instr,        32'h0000_0013);
    check("rst_count",       32'(count),       32'd0);
    check("rst_overflow",    32'(overflow_err), 32'd0);

    // Fill to full with decode stalled
    rst         = 1'b1;
    fetch_pc    = 32'h0;
    fetch_instr = 32'h0050_0093;
    tick();
    check("fill1_count",     32'(count),     32'd1);
    check("fill1_dec_valid", 32'(dec_valid), 32'd1);
    check("fill1_dec_pc",    dec_pc,         32'h0);
    check("fill1_dec_instr", dec_instr,      32'h0050_0093);
    fetch_pc    = 32'h4;
    fetch_instr = 32'h00A0_0113;
    tick();
    check("fill2_count",       32'(count),       32'd2);
    check("fill2_fetch_ready", 32'(fetch_ready), 32'd0);
    check("fill2_dec_pc",      dec_pc,           32'h0);

    // Drain in order
    fetch_valid = 1'b0;
    dec_ready   = 1'b1;
    tick();
    check("drain1_count",       32'(count),       32'd1);
    check("drain1_fetch_ready", 32'(fetch_ready), 32'd1);
    check("drain1_dec_pc",      dec_pc,           32'h4);
    check("drain1_dec_instr",   dec_instr,        32'h00A0_0113);
    tick();
    check("drain2_dec_valid", 32'(dec_valid), 32'd0);
    check("drain2_dec_pc",    dec_pc,         32'h0);
    check("drain2_dec_instr", dec_instr,      32'h0000_0013);

    // Streaming: push and pop every cycle, PCs 0x0..0x24
    fetch_valid = 1'b1;
    dec_ready   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fetch_pc    = 32'(4 * i);
      fetch_instr = 32'h0000_1000 + 32'(i);
      if (i > 0) begin
        check("stream_dec_pc",    dec_pc,    32'(4 * (i - 1)));
        check("stream_dec_instr", dec_instr, 32'h0000_1000 + 32'(i - 1));
      end
      check("stream_fetch_ready", 32'(fetch_ready), 32'd1);
      tick();
      check("stream_count", 32'(count), 32'd1);
    end
    check("stream_last_pc", dec_pc, 32'h24);
    fetch_valid = 1'b0;
    tick();
    check("stream_empty", 32'(count), 32'd0);

    // Wrap-around: one resident entry, then 5 push/pop cycles
    dec_ready   = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    fetch_instr = 32'hAAAA_0100;
    tick();
    dec_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("wrap_dec_pc",    dec_pc,    32'h100 + 32'(4 * (i - 1)));
      check("wrap_dec_instr", dec_instr, 32'hAAAA_0100 + 32'(4 * (i - 1)));
      fetch_pc    = 32'h100 + 32'(4 * i);
      fetch_instr = 32'hAAAA_0100 + 32'(4 * i);
      tick();
      check("wrap_count", 32'(count), 32'd1);
    end
    check("wrap_final_pc", dec_pc, 32'h114);
    fetch_valid = 1'b0;
    tick();
    check("wrap_drained", 32'(count), 32'd0);

    // Flush at full with a same-cycle push attempt and pop
    dec_ready   = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0;
    fetch_instr = 32'h1111_0000;
    tick();
    fetch_pc    = 32'h4;
    fetch_instr = 32'h1111_0004;
    tick();
    check("preflush_count", 32'(count), 32'd2);
    flush       = 1'b1;
    dec_ready   = 1'b1;
    fetch_pc    = 32'h8;
    fetch_instr = 32'h1111_0008;
    tick();
    check("flush_count",       32'(count),        32'd0);
    check("flush_dec_valid",   32'(dec_valid),    32'd0);
    check("flush_fetch_ready", 32'(fetch_ready),  32'd1);
    check("flush_dec_instr",   dec_instr,         32'h0000_0013);
    check("flush_overflow",    32'(overflow_err), 32'd0);
    flush       = 1'b0;
    dec_ready   = 1'b0;
    fetch_pc    = 32'h40;
    fetch_instr = 32'h2222_0040;
    tick();
    check("postflush_count",  32'(count), 32'd1);
    check("postflush_dec_pc", dec_pc,     32'h40);
    check("postflush_instr",  dec_instr,  32'h2222_0040);

    // Flush at count 1 with a same-cycle push and pop: both discarded
    flush       = 1'b1;
    dec_ready   = 1'b1;
    fetch_pc    = 32'h44;
    fetch_instr = 32'h2222_0044;
    tick();
    check("flush1_count",     32'(count),     32'd0);
    check("flush1_dec_valid", 32'(dec_valid), 32'd0);
    flush = 1'b0;

    // Overflow: push while full with decode stalled
    dec_ready   = 1'b0;
    fetch_pc    = 32'h80;
    fetch_instr = 32'h3333_0080;
    tick();
    fetch_pc    = 32'h84;
    fetch_instr = 32'h3333_0084;
    tick();
    check("ovf_pre_err",   32'(overflow_err), 32'd0);
    check("ovf_pre_count", 32'(count),        32'd2);
    fetch_pc    = 32'h88;
    fetch_instr = 32'h3333_0088;
    tick();
    check("ovf_err",    32'(overflow_err), 32'd1);
    check("ovf_count",  32'(count),        32'd2);
    check("ovf_dec_pc", dec_pc,            32'h80);
    fetch_valid = 1'b0;
    dec_ready   = 1'b1;
    tick();
    check("ovf_drain_pc", dec_pc, 32'h84);
    tick();
    check("ovf_drained_count", 32'(count),        32'd0);
    check("ovf_sticky",        32'(overflow_err), 32'd1);

    // Reset mid-operation with an entry resident
    dec_ready   = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = 32'hC0;
    fetch_instr = 32'h4444_00C0;
    tick();
    check("mid_count", 32'(count), 32'd1);
    fetch_valid = 1'b0;
    rst         = 1'b0;
    tick();
    check("mid_rst_err",       32'(overflow_err), 32'd0);
    check("mid_rst_count",     32'(count),        32'd0);
    check("mid_rst_dec_valid", 32'(dec_valid),    32'd0);
    check("mid_rst_dec_instr", dec_instr,         32'h0000_0013);
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_if_id_queue
`default_nettype wire
